data_memory_arbiter: RTL
========================

# data_memory_arbiter

Shares the single-port `data_memory` between two requesters: the pipeline MEM stage (port A) and the debug/program loader (port B). It arbitrates with fixed priority to A and guarantees B a slot after a bounded number of A grants. It supports locked bursts from B and rejects misaligned or out-of-range accesses before they reach memory. Read data is routed back to the owner one cycle after the grant.

## Interface

Parameters:

- `STARVE_LIMIT`, default 4: consecutive cycles in which B requests and A is granted before B is forced a slot; legal range is 1..15.
- `MEM_BYTES`, default 256: size of the data memory in bytes; any address at or above this is out of range.

Ports:

- `CLK` in 1: the only clock. Everything is updated on `posedge CLK`.
- `RST` in 1: synchronous, active-high reset. It is sampled on `posedge CLK`.
- `A_Req`, `B_Req` in 1: request valid. The requester holds the request and its payload until it sees `Gnt`.
- `A_W_En`, `B_W_En` in 1: 1 = store, 0 = load.
- `A_Control`, `B_Control` in 3: access size and sign, using the `definitions` `MEM_*` encoding.
- `A_Addr`, `B_Addr` in 32: byte address.
- `A_W_Data`, `B_W_Data` in 32: store data, taken from the low bits.
- `B_Lock` in 1: while it is 1 on a granted B beat, B keeps the memory for its next beat.
- `A_Gnt`, `B_Gnt` out 1: combinational grant. A transfer occurs on the edge where `Req && Gnt`.
- `A_R_Valid`, `B_R_Valid` out 1: registered one-cycle response pulse, for loads and stores alike.
- `A_Err`, `B_Err` out 1: qualifies `R_Valid`. 1 means the access was rejected.
- `A_R_Data`, `B_R_Data` out 32: load data. It is 0 on stores, on errors, and whenever `R_Valid` is 0.
- `MEM_W_En`, `MEM_Control`, `RW_Addr`, `W_Data` out: drive `data_memory`.
- `MEM_R_Data` in 32: `R_Data` from `data_memory`.

## Operation

Arbitration FSM, state register `arb_state`:

- **`PRIO_A`**
  - If `A_Req` is set, grant A. If `B_Req` is also set, `starve_cnt++`. When the count reaches `STARVE_LIMIT`, go to `PRIO_B`.
  - Otherwise, if `B_Req` is set, grant B and set `starve_cnt=0`. If `B_Lock` is 1, go to `LOCK_B`.
- **`PRIO_B`**
  - If `B_Req` is set, grant B. If `B_Lock` is 1, go to `LOCK_B`; otherwise go to `PRIO_A`.
  - If `B_Req` is not set, grant A if `A_Req` is set, then go to `PRIO_A`.
  - `starve_cnt` is cleared on entry to this state.
- **`LOCK_B`**
  - A is never granted.
  - B is granted while `B_Req` is set. A granted beat with `B_Lock=0`, or `B_Req=0`, returns to `PRIO_A`.

General rules:

- At most one grant per cycle. The grant is a function of `arb_state`, `starve_cnt` and the current request inputs.
- Memory outputs come from the granted port. With no grant, `MEM_W_En=0` and the other memory outputs hold their previous values.
- An access is rejected (error) when any of these holds:
  - halfword size with `Addr[0]=1`
  - word size with `Addr[1:0]!=0`
  - `Addr >= MEM_BYTES`
- A rejected access still consumes its grant, but the arbiter forces `MEM_W_En=0`. The owner then gets `R_Valid=1`, `Err=1`, `R_Data=0`.
- Owner tracking: a registered owner, error flag and load flag are captured on each grant and used to route `MEM_R_Data` in the next cycle.

## Timing

- Reset values:
  - `arb_state=PRIO_A`, `starve_cnt=0`.
  - All `R_Valid`, `Err` and `R_Data` outputs are 0.
  - While `RST=1`, both grants are forced to 0 and `MEM_W_En=0`.
- Reset in the middle of a locked burst abandons the lock. Any response pending from the pre-reset cycle is dropped.
- Latency for a grant in cycle N:
  - Memory captures a store at the end of cycle N.
  - The owner's `R_Valid` is high in cycle N+1. For a load, `R_Data` carries `MEM_R_Data`, which `data_memory` guarantees is valid and extended in cycle N+1 for an access presented in cycle N.
- Throughput is one access per cycle. Back-to-back grants are allowed; a response and a new grant may occur in the same cycle.
- A requester that drops `Req` without a grant has no effect. Changing the payload while waiting is legal, and the payload in the grant cycle is used.
- `starve_cnt` saturates at `STARVE_LIMIT`.

## Structure

- `definitions` package:
  - Holds the `arb_state_t` enum {`PRIO_A`, `PRIO_B`, `LOCK_B`} and an `owner_t` enum {`OWN_A`, `OWN_B`}.
  - Reuses the existing `MEM_*` codes and `CLOCK_PERIOD`.
- One sub-module: `mem_access_checker`. It is combinational, takes `Control`, `Addr` and `MEM_BYTES`, and produces the error bit. It is instantiated once per port.
- The top level contains the FSM, the counter, the response registers and the output muxes, and instantiates `data_memory` externally.

## Test plan

- **Reset:** assert `RST` with both `Req` high. Both `Gnt` must stay 0, `MEM_W_En` must be 0, and all `R_Valid` outputs 0.
- **Simultaneous requests:** A and B request every cycle with `STARVE_LIMIT=4`. Expect A granted for 4 cycles, B granted in cycle 5, then A again; the pattern repeats.
- **Locked burst:** B stores words `0x11`, `0x22`, `0x33` to addresses `0x00`, `0x04`, `0x08`, with `B_Lock` high on the first two beats, while A requests throughout. `A_Gnt` must be 0 for all three beats and 1 on the fourth cycle. A subsequent read of `0x08` by A returns `0x0000_0033`.
- **Store then load:** A stores `MEM_BYTE` `0xFF` at `0x00`, then loads `MEM_BYTE` from `0x00`. `A_R_Valid` must be high in the following cycle with `A_R_Data=0xFFFF_FFFF`; the same load as `MEM_BYTE_UNSIGNED` returns `0x0000_00FF`.
- **Error rejection:**
  - A `MEM_WORD` store of `0xDEAD_BEEF` to `0x02` must give `A_Err=1` next cycle and leave memory unchanged.
  - A `MEM_HALFWORD` load from `0x101` must give `A_Err=1` with `A_R_Data=0`.
- **Reset mid-burst:** assert `RST` during `LOCK_B`. After release, A must be granted immediately even though `B_Req` remains high.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: memory access codes and arbiter enums.
package definitions;

  localparam int CLOCK_PERIOD = 10;

  localparam logic [2:0] MEM_BYTE              = 3'b000;
  localparam logic [2:0] MEM_HALFWORD          = 3'b001;
  localparam logic [2:0] MEM_WORD              = 3'b010;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

  typedef enum logic [1:0] {
    PRIO_A,
    PRIO_B,
    LOCK_B
  } arb_state_t;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_t;

endpackage

// File: rtl/data_memory_arbiter_checker.sv
// Combinational access filter: flags misaligned halfword/word accesses and out-of-range addresses.
module mem_access_checker
  import definitions::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic [2:0]  Control_i,
  input  logic [31:0] Addr_i,
  output logic        Err_o
);

  logic [1:0] size;
  logic       misaligned;
  logic       unused_sign;

  // Bit 2 only selects sign extension, which has no bearing on legality.
  assign unused_sign = Control_i[2];
  assign size        = Control_i[1:0];

  always_comb begin
    misaligned = 1'b0;
    if (size == MEM_HALFWORD[1:0] && Addr_i[0])
      misaligned = 1'b1;
    if (size == MEM_WORD[1:0] && Addr_i[1:0] != 2'b00)
      misaligned = 1'b1;
    Err_o = misaligned || (Addr_i >= 32'(MEM_BYTES));
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Fixed-priority arbiter sharing data_memory between the MEM stage (A) and the loader (B),
// with starvation guard for B, locked B bursts, access rejection and response routing.
module data_memory_arbiter
  import definitions::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_BYTES    = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        A_Req,
  input  logic        A_W_En,
  input  logic [2:0]  A_Control,
  input  logic [31:0] A_Addr,
  input  logic [31:0] A_W_Data,
  input  logic        B_Req,
  input  logic        B_W_En,
  input  logic [2:0]  B_Control,
  input  logic [31:0] B_Addr,
  input  logic [31:0] B_W_Data,
  input  logic        B_Lock,
  output logic        A_Gnt,
  output logic        B_Gnt,
  output logic        A_R_Valid,
  output logic        B_R_Valid,
  output logic        A_Err,
  output logic        B_Err,
  output logic [31:0] A_R_Data,
  output logic [31:0] B_R_Data,
  output logic        MEM_W_En,
  output logic [2:0]  MEM_Control,
  output logic [31:0] RW_Addr,
  output logic [31:0] W_Data,
  input  logic [31:0] MEM_R_Data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;

  logic        a_err, b_err;
  logic        any_gnt, sel_we, sel_err;
  logic [2:0]  ctl_q, ctl_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

  logic        valid_q, err_q, load_q;
  owner_t      owner_q;
  logic        a_vld, b_vld;

  mem_access_checker #(.MEM_BYTES(MEM_BYTES)) u_chk_a (
    .Control_i (A_Control),
    .Addr_i    (A_Addr),
    .Err_o     (a_err)
  );

  mem_access_checker #(.MEM_BYTES(MEM_BYTES)) u_chk_b (
    .Control_i (B_Control),
    .Addr_i    (B_Addr),
    .Err_o     (b_err)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PRIO_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q >= LIMIT) ? LIMIT : cnt_q + 4'd1;
    case (state_q)
      PRIO_A: begin
        if (A_Req) begin
          if (B_Req) begin
            cnt_d = cnt_inc;
            // Counter restarts as B is promoted, so PRIO_B always begins a fresh window.
            if (cnt_inc == LIMIT) begin
              state_d = PRIO_B;
              cnt_d   = '0;
            end
          end
        end else if (B_Req) begin
          cnt_d = '0;
          if (B_Lock) state_d = LOCK_B;
        end
      end
      PRIO_B:  state_d = (B_Req && B_Lock) ? LOCK_B : PRIO_A;
      LOCK_B:  if (!B_Req || !B_Lock) state_d = PRIO_A;
      default: state_d = PRIO_A;
    endcase
  end

  always_comb begin
    A_Gnt = 1'b0;
    B_Gnt = 1'b0;
    if (!RST) begin
      case (state_q)
        PRIO_A: begin
          A_Gnt = A_Req;
          B_Gnt = !A_Req && B_Req;
        end
        PRIO_B: begin
          B_Gnt = B_Req;
          A_Gnt = !B_Req && A_Req;
        end
        LOCK_B:  B_Gnt = B_Req;
        default: ;
      endcase
    end
  end

  // Memory side: follow the granted port, otherwise hold the last presented access.
  always_comb begin
    any_gnt = A_Gnt || B_Gnt;
    sel_we  = B_Gnt ? B_W_En : A_W_En;
    sel_err = B_Gnt ? b_err  : a_err;
    ctl_d   = ctl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (A_Gnt) begin
      ctl_d   = A_Control;
      addr_d  = A_Addr;
      wdata_d = A_W_Data;
    end else if (B_Gnt) begin
      ctl_d   = B_Control;
      addr_d  = B_Addr;
      wdata_d = B_W_Data;
    end
    MEM_W_En    = any_gnt && sel_we && !sel_err;
    MEM_Control = ctl_d;
    RW_Addr     = addr_d;
    W_Data      = wdata_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      owner_q <= OWN_A;
    end else begin
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= any_gnt;
      err_q   <= sel_err;
      load_q  <= !sel_we;
      owner_q <= B_Gnt ? OWN_B : OWN_A;
    end
  end

  always_comb begin
    a_vld     = valid_q && (owner_q == OWN_A) && !RST;
    b_vld     = valid_q && (owner_q == OWN_B) && !RST;
    A_R_Valid = a_vld;
    B_R_Valid = b_vld;
    A_Err     = a_vld && err_q;
    B_Err     = b_vld && err_q;
    A_R_Data  = (a_vld && load_q && !err_q) ? MEM_R_Data : '0;
    B_R_Data  = (b_vld && load_q && !err_q) ? MEM_R_Data : '0;
  end

endmodule
